// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller: PC mux selects,
// FSM encoding, LM/SM mask geometry and the pipeline flush vector.
package fetch_ctrl_pkg;

    localparam int NREG = 8;
    localparam int IDXW = 3;

    localparam logic [2:0] PC_SEL_INC      = 3'd0;
    localparam logic [2:0] PC_SEL_S3_RF    = 3'd1;
    localparam logic [2:0] PC_SEL_S5_MEM   = 3'd2;
    localparam logic [2:0] PC_SEL_S2_PCIMM = 3'd3;
    localparam logic [2:0] PC_SEL_S3_PCINC = 3'd4;
    localparam logic [2:0] PC_SEL_S2_IMM   = 3'd5;
    localparam logic [2:0] PC_SEL_S4_ALU   = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        LMSM = 1'b1
    } fetchState_t;

    typedef struct packed {
        logic ifid;
        logic idrr;
        logic rrex;
        logic exmem;
    } flushVec_t;

    // A redirect from stage N squashes every pipeline register younger than N.
    function automatic flushVec_t flushUpTo(input int unsigned stage);
        flushVec_t f;
        f.ifid  = (stage >= 2);
        f.idrr  = (stage >= 3);
        f.rrex  = (stage >= 4);
        f.exmem = (stage >= 5);
        return f;
    endfunction

endpackage

// File: rtl/priority_enc8.sv
// Lowest-set-bit encoder with a valid flag; used to walk LM/SM register masks
// in ascending index order.
module priority_enc8
    import fetch_ctrl_pkg::*;
(
    input  logic [NREG-1:0] maskIn,
    output logic [IDXW-1:0] lowIdx,
    output logic            valid
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        lowIdx = '0;
        valid  = 1'b0;
        // Scanning downward lets the lowest set bit make the final assignment.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (maskIn[i]) begin
                lowIdx = IDXW'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage control: redirect arbitration, load-use stalls, LM/SM micro-op
// sequencing, and flush/bubble generation for the younger pipeline registers.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            redir_s2_jal,
    input  logic            redir_s2_lhi,
    input  logic            redir_s3_jlr,
    input  logic            redir_s3_restore,
    input  logic            redir_s4_alu,
    input  logic            redir_s5_mem,
    input  logic            load_use,
    input  logic            lmsm_start,
    input  logic [NREG-1:0] lmsm_mask,
    output logic [2:0]      pc_sel,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            flush_ifid,
    output logic            flush_idrr,
    output logic            flush_rrex,
    output logic            flush_exmem,
    output logic            bubble_rrex,
    output logic            lmsm_busy,
    output logic [IDXW-1:0] lmsm_idx,
    output logic            lmsm_last
);

    fetchState_t     stateQ, stateD;
    logic [NREG-1:0] pendMaskQ, pendMaskD;
    logic [NREG-1:0] encIn, remainMask;
    logic [IDXW-1:0] encIdx;
    logic            encValid;
    logic            single;
    logic            lateRedirect, earlyRedirect;
    flushVec_t       flushSel;

    // One encoder serves both the incoming mask (IDLE) and the pending mask (LMSM).
    assign encIn = (stateQ == LMSM) ? pendMaskQ : lmsm_mask;

    priority_enc8 u_enc (
        .maskIn (encIn),
        .lowIdx (encIdx),
        .valid  (encValid)
    );

    assign remainMask = encIn & ~(NREG'(1) << encIdx);
    assign single     = encValid && (remainMask == '0);

    assign lateRedirect  = redir_s5_mem | redir_s4_alu | redir_s3_jlr | redir_s3_restore;
    // Stage 2 is occupied by the LM/SM itself while the expansion runs.
    assign earlyRedirect = (stateQ == IDLE) && (redir_s2_jal | redir_s2_lhi);

    always_comb begin
        pc_sel      = PC_SEL_INC;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flushSel    = '0;
        bubble_rrex = 1'b0;
        lmsm_busy   = 1'b0;
        lmsm_idx    = '0;
        lmsm_last   = 1'b0;
        stateD      = stateQ;
        pendMaskD   = pendMaskQ;

        if (redir_s5_mem) begin
            pc_sel   = PC_SEL_S5_MEM;
            flushSel = flushUpTo(5);
        end else if (redir_s4_alu) begin
            pc_sel   = PC_SEL_S4_ALU;
            flushSel = flushUpTo(4);
        end else if (redir_s3_jlr) begin
            pc_sel   = PC_SEL_S3_RF;
            flushSel = flushUpTo(3);
        end else if (redir_s3_restore) begin
            pc_sel   = PC_SEL_S3_PCINC;
            flushSel = flushUpTo(3);
        end else if (earlyRedirect && redir_s2_jal) begin
            pc_sel   = PC_SEL_S2_PCIMM;
            flushSel = flushUpTo(2);
        end else if (earlyRedirect) begin
            pc_sel   = PC_SEL_S2_IMM;
            flushSel = flushUpTo(2);
        end

        if (lateRedirect) begin
            stateD    = IDLE;
            pendMaskD = '0;
        end else if (earlyRedirect) begin
            // Redirect select and flushes are already set above.
        end else if (stateQ == LMSM) begin
            stateD    = IDLE;
            pendMaskD = '0;
            if (encValid) begin
                lmsm_busy = 1'b1;
                lmsm_idx  = encIdx;
                lmsm_last = single;
                pendMaskD = remainMask;
                if (!single) begin
                    stateD     = LMSM;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            bubble_rrex = 1'b1;
        end else if (lmsm_start && encValid) begin
            lmsm_busy = 1'b1;
            lmsm_idx  = encIdx;
            lmsm_last = single;
            if (!single) begin
                stateD     = LMSM;
                pendMaskD  = remainMask;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end
        end

        if (reset) begin
            pc_sel      = PC_SEL_INC;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            flushSel    = '1;
            bubble_rrex = 1'b0;
            lmsm_busy   = 1'b0;
            lmsm_idx    = '0;
            lmsm_last   = 1'b0;
        end
    end

    assign flush_ifid  = flushSel.ifid;
    assign flush_idrr  = flushSel.idrr;
    assign flush_rrex  = flushSel.rrex;
    assign flush_exmem = flushSel.exmem;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so both registers update from pre-edge values.
        if (reset) begin
            stateQ    <= IDLE;
            pendMaskQ <= '0;
        end else begin
            stateQ    <= stateD;
            pendMaskQ <= pendMaskD;
        end
    end

endmodule
